// File: rtl/nnrv_regfile_sb.sv
// nnrv_regfile_sb: integer register file with a per-register busy scoreboard.
//
// Decode/issue reads operands through the read ports and marks destinations busy
// with i_iss_en/i_iss_idx. Writeback writes results through the write ports, which
// also clears the destination's busy bit. Register 0 reads as zero and is never busy.
//
// Optional feature (compile-time macro NNRV_REGFILE_BYPASS_EN):
//   defined   - a read whose index matches an enabled same-cycle write returns that
//               write's data (highest write port wins) and reports not busy.
//   undefined - reads see stored registers only; writes are visible next cycle.
//
// Ports:
//   i_clk, i_rst  clock; asynchronous active-high reset
//   i_rd_en       per-port read enable               [RD_PORTS]
//   i_rd_idx      read indices, port p at [p*AW +: AW]
//   o_rd_data     read data, port p at [p*XLEN +: XLEN]
//   o_rd_busy     source of port p is busy
//   o_hazard      OR of o_rd_busy
//   i_wr_en       per-port write enable              [WR_PORTS]
//   i_wr_idx      write indices, port w at [w*AW +: AW]
//   i_wr_data     write data, port w at [w*XLEN +: XLEN]
//   i_iss_en      mark i_iss_idx busy
//   i_iss_idx     destination being issued
//   o_iss_ready   i_iss_idx not busy (WAW check, no bypass)
//   i_flush       clear all busy bits
//   o_busy_cnt    number of busy registers (registered)

module nnrv_regfile_sb #(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned REG_NUM  = 32,
    parameter int unsigned RD_PORTS = 2,
    parameter int unsigned WR_PORTS = 1,
    localparam int unsigned AW      = $clog2(REG_NUM)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [RD_PORTS-1:0]      i_rd_en,
    input  logic [RD_PORTS*AW-1:0]   i_rd_idx,
    output logic [RD_PORTS*XLEN-1:0] o_rd_data,
    output logic [RD_PORTS-1:0]      o_rd_busy,
    output logic                     o_hazard,
    input  logic [WR_PORTS-1:0]      i_wr_en,
    input  logic [WR_PORTS*AW-1:0]   i_wr_idx,
    input  logic [WR_PORTS*XLEN-1:0] i_wr_data,
    input  logic                     i_iss_en,
    input  logic [AW-1:0]            i_iss_idx,
    output logic                     o_iss_ready,
    input  logic                     i_flush,
    output logic [AW:0]              o_busy_cnt
);

    logic [XLEN-1:0]    regs_q [REG_NUM];
    logic [XLEN-1:0]    regs_d [REG_NUM];
    logic [REG_NUM-1:0] busy_q;
    logic [REG_NUM-1:0] busy_d;
    logic [AW:0]        busy_cnt_q;
    logic [AW:0]        busy_cnt_d;

    logic [AW-1:0]      wr_idx  [WR_PORTS];
    logic [XLEN-1:0]    wr_data [WR_PORTS];
    logic [WR_PORTS-1:0] wr_act;
    logic [AW-1:0]      rd_idx  [RD_PORTS];

    // Unpack the flat port buses; a write is only "active" for a nonzero index.
    always_comb begin
        for (int w = 0; w < int'(WR_PORTS); w++) begin
            wr_idx[w]  = i_wr_idx[w*AW +: AW];
            wr_data[w] = i_wr_data[w*XLEN +: XLEN];
            wr_act[w]  = i_wr_en[w] && (i_wr_idx[w*AW +: AW] != '0);
        end
        for (int p = 0; p < int'(RD_PORTS); p++) begin
            rd_idx[p] = i_rd_idx[p*AW +: AW];
        end
    end

    // Next state. Loop order makes the higher write port win on an index clash;
    // issue is applied after the write-clear so a new producer keeps the bit set,
    // and flush is applied last so it overrides a same-cycle issue.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int w = 0; w < int'(WR_PORTS); w++) begin
            if (wr_act[w]) begin
                regs_d[wr_idx[w]] = wr_data[w];
                busy_d[wr_idx[w]] = 1'b0;
            end
        end
        if (i_iss_en && (i_iss_idx != '0)) begin
            busy_d[i_iss_idx] = 1'b1;
        end
        if (i_flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        busy_cnt_d = '0;
        for (int i = 0; i < int'(REG_NUM); i++) begin
            busy_cnt_d = busy_cnt_d + {{AW{1'b0}}, busy_d[i]};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            regs_q     <= '{default: '0};
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    // Read ports
    always_comb begin
        o_rd_data = '0;
        o_rd_busy = '0;
        for (int p = 0; p < int'(RD_PORTS); p++) begin
            if (i_rd_en[p] && (rd_idx[p] != '0)) begin
                o_rd_data[p*XLEN +: XLEN] = regs_q[rd_idx[p]];
                o_rd_busy[p]              = busy_q[rd_idx[p]];
`ifdef NNRV_REGFILE_BYPASS_EN
                for (int w = 0; w < int'(WR_PORTS); w++) begin
                    if (wr_act[w] && (wr_idx[w] == rd_idx[p])) begin
                        o_rd_data[p*XLEN +: XLEN] = wr_data[w];
                        o_rd_busy[p]              = 1'b0;
                    end
                end
`endif
            end
        end
    end

    assign o_hazard    = |o_rd_busy;
    // Deliberately uses stored state only: a same-cycle write does not free the slot.
    assign o_iss_ready = (i_iss_idx == '0) || !busy_q[i_iss_idx];
    assign o_busy_cnt  = busy_cnt_q;

endmodule

// File: tb/tb_nnrv_regfile_sb.sv
module tb_nnrv_regfile_sb;

    localparam int XLEN = 64;
    localparam int RN   = 32;
    localparam int AW   = 5;
`ifdef NNRV_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic [1:0]      i_rd_en;
    logic [2*AW-1:0] i_rd_idx;
    logic [2*XLEN-1:0] o_rd_data;
    logic [1:0]      o_rd_busy;
    logic            o_hazard;
    logic [1:0]      i_wr_en;
    logic [2*AW-1:0] i_wr_idx;
    logic [2*XLEN-1:0] i_wr_data;
    logic            i_iss_en;
    logic [AW-1:0]   i_iss_idx;
    logic            o_iss_ready;
    logic            i_flush;
    logic [AW:0]     o_busy_cnt;

    nnrv_regfile_sb #(
        .XLEN(XLEN), .REG_NUM(RN), .RD_PORTS(2), .WR_PORTS(2)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_rd_en(i_rd_en), .i_rd_idx(i_rd_idx), .o_rd_data(o_rd_data),
        .o_rd_busy(o_rd_busy), .o_hazard(o_hazard),
        .i_wr_en(i_wr_en), .i_wr_idx(i_wr_idx), .i_wr_data(i_wr_data),
        .i_iss_en(i_iss_en), .i_iss_idx(i_iss_idx), .o_iss_ready(o_iss_ready),
        .i_flush(i_flush), .o_busy_cnt(o_busy_cnt)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: architectural state as plain arrays.
    logic [XLEN-1:0] m_regs [RN];
    bit              m_busy [RN];

    typedef struct {
        int          rd_en, ri0, ri1, we, wi0, wi1;
        logic [63:0] wd0, wd1;
        int          iss, isi, fl;
        logic [63:0] xd0, xd1;
        int          xb0, xb1, xhz, xrdy, xcnt;
    } vec_t;
    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < RN; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    function automatic int model_cnt();
        int c = 0;
        for (int i = 0; i < RN; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    // Expected read result of port p given the current inputs and model state.
    task automatic model_read(input int p, output logic [63:0] d, output bit b);
        int idx = (p == 0) ? int'(i_rd_idx[AW-1:0]) : int'(i_rd_idx[2*AW-1:AW]);
        d = '0;
        b = 1'b0;
        if (i_rd_en[p] && idx != 0) begin
            d = m_regs[idx];
            b = m_busy[idx];
            if (BYP) begin
                for (int w = 0; w < 2; w++) begin
                    int wi = (w == 0) ? int'(i_wr_idx[AW-1:0]) : int'(i_wr_idx[2*AW-1:AW]);
                    if (i_wr_en[w] && wi == idx) begin
                        d = (w == 0) ? i_wr_data[63:0] : i_wr_data[127:64];
                        b = 1'b0;
                    end
                end
            end
        end
    endtask

    // Clock edge: model consumes the same inputs the DUT samples.
    task automatic tick();
        @(posedge i_clk);
        for (int w = 0; w < 2; w++) begin
            int wi = (w == 0) ? int'(i_wr_idx[AW-1:0]) : int'(i_wr_idx[2*AW-1:AW]);
            if (i_wr_en[w] && wi != 0) begin
                m_regs[wi] = (w == 0) ? i_wr_data[63:0] : i_wr_data[127:64];
                m_busy[wi] = 1'b0;
            end
        end
        if (i_iss_en && i_iss_idx != 0) m_busy[i_iss_idx] = 1'b1;
        if (i_flush) for (int i = 0; i < RN; i++) m_busy[i] = 1'b0;
        #1;
    endtask

    task automatic idle();
        i_rd_en = '0; i_rd_idx = '0; i_wr_en = '0; i_wr_idx = '0; i_wr_data = '0;
        i_iss_en = 1'b0; i_iss_idx = '0; i_flush = 1'b0;
    endtask

    task automatic drive(input vec_t v);
        i_rd_en   = 2'(v.rd_en);
        i_rd_idx  = {5'(v.ri1), 5'(v.ri0)};
        i_wr_en   = 2'(v.we);
        i_wr_idx  = {5'(v.wi1), 5'(v.wi0)};
        i_wr_data = {v.wd1, v.wd0};
        i_iss_en  = (v.iss != 0);
        i_iss_idx = 5'(v.isi);
        i_flush   = (v.fl != 0);
    endtask

    initial begin
        logic [63:0] ed0, ed1;
        bit eb0, eb1;
        int bb = BYP ? 1 : 0;

        //          rd_en ri0 ri1 we wi0 wi1 wd0          wd1        iss isi fl  xd0        xd1      xb0 xb1 xhz rdy cnt
        vecs[0]  = '{0, 0, 0, 1, 5, 0, 64'h1234, 64'h0, 0, 0, 0, 64'h0, 64'h0, 0, 0, 0, 1, 0};
        vecs[1]  = '{2, 0, 5, 1, 0, 0, 64'hFFFF, 64'h0, 0, 0, 0, 64'h0, 64'h1234, 0, 0, 0, 1, 0};
        vecs[2]  = '{1, 0, 0, 3, 7, 7, 64'hAA, 64'hBB, 0, 0, 0, 64'h0, 64'h0, 0, 0, 0, 1, 0};
        vecs[3]  = '{1, 7, 0, 0, 0, 0, 64'h0, 64'h0, 1, 3, 0, 64'hBB, 64'h0, 0, 0, 0, 1, 0};
        vecs[4]  = '{3, 3, 7, 0, 0, 0, 64'h0, 64'h0, 0, 3, 0, 64'h0, 64'hBB, 1, 0, 1, 0, 1};
        vecs[5]  = '{1, 3, 0, 1, 3, 0, 64'h55, 64'h0, 0, 3, 0,
                     BYP ? 64'h55 : 64'h0, 64'h0, 1 - bb, 0, 1 - bb, 0, 1};
        vecs[6]  = '{1, 3, 0, 1, 9, 0, 64'h99, 64'h0, 1, 9, 0, 64'h55, 64'h0, 0, 0, 0, 1, 0};
        vecs[7]  = '{3, 9, 3, 0, 0, 0, 64'h0, 64'h0, 1, 10, 1, 64'h99, 64'h55, 1, 0, 1, 1, 1};
        vecs[8]  = '{3, 9, 10, 0, 0, 0, 64'h0, 64'h0, 0, 0, 0, 64'h99, 64'h0, 0, 0, 0, 1, 0};
        vecs[9]  = '{0, 0, 0, 0, 0, 0, 64'h0, 64'h0, 1, 4, 0, 64'h0, 64'h0, 0, 0, 0, 1, 0};
        vecs[10] = '{1, 4, 0, 1, 4, 0, 64'h77, 64'h0, 0, 0, 0,
                     BYP ? 64'h77 : 64'h0, 64'h0, 1 - bb, 0, 1 - bb, 1, 1};
        vecs[11] = '{1, 4, 0, 0, 0, 0, 64'h0, 64'h0, 0, 0, 0, 64'h77, 64'h0, 0, 0, 0, 1, 0};

        // Reset and sweep every register on both ports.
        idle();
        i_rst = 1'b1;
        model_reset();
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        i_rd_en = 2'b11;
        for (int i = 1; i < RN; i++) begin
            i_rd_idx  = {5'(i), 5'(i)};
            i_iss_idx = 5'(i);
            #1;
            chk($sformatf("rst_d0_x%0d", i), o_rd_data[63:0], 64'h0);
            chk($sformatf("rst_d1_x%0d", i), o_rd_data[127:64], 64'h0);
            chk($sformatf("rst_hz_x%0d", i), 64'(o_hazard), 64'h0);
            chk($sformatf("rst_rdy_x%0d", i), 64'(o_iss_ready), 64'h1);
        end
        chk("rst_cnt", 64'(o_busy_cnt), 64'h0);
        idle();
        tick();

        // Directed table.
        for (int k = 0; k < 12; k++) begin
            drive(vecs[k]);
            @(negedge i_clk);
            chk($sformatf("v%0d_d0", k), o_rd_data[63:0], vecs[k].xd0);
            chk($sformatf("v%0d_d1", k), o_rd_data[127:64], vecs[k].xd1);
            chk($sformatf("v%0d_b0", k), 64'(o_rd_busy[0]), 64'(vecs[k].xb0));
            chk($sformatf("v%0d_b1", k), 64'(o_rd_busy[1]), 64'(vecs[k].xb1));
            chk($sformatf("v%0d_hz", k), 64'(o_hazard), 64'(vecs[k].xhz));
            chk($sformatf("v%0d_rdy", k), 64'(o_iss_ready), 64'(vecs[k].xrdy));
            chk($sformatf("v%0d_cnt", k), 64'(o_busy_cnt), 64'(vecs[k].xcnt));
            tick();
        end

        // Mid-operation asynchronous reset with pending issue and write.
        idle();
        i_iss_en = 1'b1; i_iss_idx = 5'd2; tick();
        i_iss_idx = 5'd6; tick();
        i_iss_idx = 5'd7;
        i_wr_en = 2'b01; i_wr_idx = {5'd0, 5'd5}; i_wr_data = {64'h0, 64'hDEAD};
        i_rd_en = 2'b11; i_rd_idx = {5'd6, 5'd2};
        @(negedge i_clk);
        chk("mid_cnt_before", 64'(o_busy_cnt), 64'd2);
        chk("mid_busy_before", 64'(o_rd_busy), 64'd3);
        i_rst = 1'b1;
        model_reset();
        #1;
        chk("mid_cnt", 64'(o_busy_cnt), 64'd0);
        chk("mid_busy", 64'(o_rd_busy), 64'd0);
        chk("mid_hz", 64'(o_hazard), 64'd0);
        i_rd_idx = {5'd7, 5'd5};
        #1;
        chk("mid_x5", o_rd_data[63:0], 64'h0);
        chk("mid_x7", o_rd_data[127:64], 64'h0);
        idle();
        #1;
        i_rst = 1'b0;
        tick();
        i_rd_en = 2'b11; i_rd_idx = {5'd7, 5'd5};
        #1;
        chk("post_x5", o_rd_data[63:0], 64'h0);
        chk("post_cnt", 64'(o_busy_cnt), 64'd0);
        idle();

        // Randomized traffic against the model; small index range forces collisions.
        for (int c = 0; c < 600; c++) begin
            i_rd_en   = 2'($urandom);
            i_rd_idx  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            i_wr_en   = 2'($urandom);
            i_wr_idx  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            i_wr_data = {$urandom, $urandom, $urandom, $urandom};
            i_iss_en  = ($urandom_range(0, 1) == 1);
            i_iss_idx = 5'($urandom_range(0, 7));
            i_flush   = ($urandom_range(0, 15) == 0);
            @(negedge i_clk);
            model_read(0, ed0, eb0);
            model_read(1, ed1, eb1);
            chk("rnd_d0", o_rd_data[63:0], ed0);
            chk("rnd_d1", o_rd_data[127:64], ed1);
            chk("rnd_b0", 64'(o_rd_busy[0]), 64'(eb0));
            chk("rnd_b1", 64'(o_rd_busy[1]), 64'(eb1));
            chk("rnd_hz", 64'(o_hazard), 64'(eb0 | eb1));
            chk("rnd_rdy", 64'(o_iss_ready), 64'(!m_busy[i_iss_idx]));
            chk("rnd_cnt", 64'(o_busy_cnt), 64'(model_cnt()));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/nnrv_regfile_sb.md
Name: nnrv_regfile_sb

Overview:
- Parametrised integer register file and scoreboard for the nnrv core.
- Configurable read-port count, one or two write ports, and a per-register busy bit for in-flight destinations.
- Raises a hazard flag when an enabled read targets a busy register.
- Sits between decode/issue, which reads operands and marks destinations, and writeback, which writes results and clears busy bits.

Parameters:
- XLEN, 64, data width of each register.
- REG_NUM, 32, number of registers; power of two, at least 2; register 0 is hard-wired zero.
- RD_PORTS, 2, number of read ports (1..4).
- WR_PORTS, 1, number of write ports (1 or 2).
- Derived, not overridable: AW = $clog2(REG_NUM).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_rd_en  in  RD_PORTS  per-port read enable
- i_rd_idx  in  RD_PORTS*AW  read indices; port p occupies bits [p*AW +: AW]
- o_rd_data  out  RD_PORTS*XLEN  read data; port p occupies bits [p*XLEN +: XLEN]
- o_rd_busy  out  RD_PORTS  source register of port p is busy (after bypass)
- o_hazard  out  1  OR of o_rd_busy
- i_wr_en  in  WR_PORTS  per-port write enable
- i_wr_idx  in  WR_PORTS*AW  write indices
- i_wr_data  in  WR_PORTS*XLEN  write data
- i_iss_en  in  1  mark i_iss_idx busy
- i_iss_idx  in  AW  destination being issued
- o_iss_ready  out  1  i_iss_idx not busy (WAW check)
- i_flush  in  1  clear all busy bits
- o_busy_cnt  out  AW+1  number of busy registers

Behaviour:
- Reset (async, i_rst=1): all registers 0, all busy bits 0, o_busy_cnt 0.
  - Combinational outputs follow from that state: o_rd_data 0, o_rd_busy 0, o_hazard 0, o_iss_ready 1.
- Read:
  - Combinational, zero latency.
  - Disabled port, or index 0: data 0, busy 0.
  - Otherwise: data = regs[idx], busy = busy[idx].
- Write:
  - On posedge, regs[idx] <= data for each enabled port with idx != 0.
  - Both write ports to the same index in one cycle: port 1 wins.
  - Writes to index 0 are ignored.
- Busy bits:
  - Update on posedge.
  - An enabled write with nonzero index clears busy[idx].
  - i_iss_en with nonzero index sets busy[idx].
  - Issue and write to the same index in the same cycle: set wins (new producer), and the data write still happens.
  - busy[0] is always 0.
  - i_flush clears every busy bit, overriding a same-cycle issue. Register writes in that cycle still commit.
- o_iss_ready:
  - = !busy[i_iss_idx], or 1 when i_iss_idx == 0.
  - A same-cycle write that clears the bit does not make it ready; the bypass does not apply here.
  - Issuing while o_iss_ready=0 is legal; the bit stays set.
- o_busy_cnt:
  - Registered population count of the busy vector, updated in the same cycle as the vector (value matches the vector after the edge).
  - Max value REG_NUM-1; no wrap is possible.
- Reset mid-operation: takes effect immediately; pending writes and issues are discarded.

Optional Feature:
- Macro: NNRV_REGFILE_BYPASS_EN.
- Defined:
  - A read port whose index matches an enabled same-cycle write (nonzero index) returns i_wr_data of that write port (port 1 wins) instead of regs[idx].
  - Its o_rd_busy is forced 0 for that cycle.
- Undefined:
  - Reads return stored regs only; the written value is visible the cycle after the write.
  - o_rd_busy reflects busy[idx] until the edge that clears it.

Test Plan:
- Reset, then read x1..x31 on all ports -> all data 0, o_hazard 0, o_busy_cnt 0, o_iss_ready 1.
- Write x5=0x1234 via port 0, next cycle read x5 on port 1 -> 0x1234; write x0=0xFFFF -> read x0 returns 0.
- Both write ports hit x7 (port0 0xAA, port1 0xBB) -> x7 reads 0xBB.
- Issue x3, next cycle read x3 -> o_rd_busy[0]=1, o_hazard=1, o_busy_cnt=1, o_iss_ready for x3 = 0; write x3=0x55 -> next cycle busy 0, data 0x55, count 0.
- Same-cycle issue and write of x9 -> x9 busy=1 with new data stored; then assert i_flush with issue x10 -> all busy 0, count 0.
- Bypass: with NNRV_REGFILE_BYPASS_EN, busy x4, write x4=0x77 and read x4 in the same cycle -> data 0x77, busy 0. Without the macro: old data, busy 1.
- Mid-operation reset: busy x2 and x6, pulse i_rst between clock edges -> immediate count 0, all data 0.
